seq_hit_window: RTL and testbench
=================================

Name: seq_hit_window

Overview:
- Downstream consumer of the overlapping 1011 pattern detector (seq_1).
- Takes the detector's one-cycle `out` pulse as `hit`, one sampled bit per clock.
- Counts hits over a fixed window of WIN_LEN clocks and reports the count, a threshold alarm and a saturation flag once per window.
- Supports single-shot and back-to-back (continuous) windows, plus abort.

Parameters:
- WIN_LEN, 16: window length in clocks (>=2).
- CNT_W, 5: width of hit accumulator and cnt_out.
- THRESH, 3: alarm when final window count >= THRESH (must fit in CNT_W bits).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- hit  in  1  match pulse from the pattern detector (`out`).
- start  in  1  begin a window; honoured only in IDLE.
- stop  in  1  abort the current window; priority over start.
- cont  in  1  sampled at window end: 1 = immediately start the next window, 0 = return to IDLE.
- busy  out  1  high while in COUNT.
- cnt_out  out  CNT_W  hit count of the last completed window; held.
- cnt_valid  out  1  one-cycle pulse when cnt_out/alarm/ovf update.
- alarm  out  1  cnt_out >= THRESH for the last completed window; held.
- ovf  out  1  accumulator saturated during the last completed window; held.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; acc, win_cnt, sat=0.
  - All outputs 0 the following cycle.
  - rst mid-window discards the window; no cnt_valid.
- FSM states: IDLE, COUNT (1-bit encoding).
- IDLE:
  - busy=0; hit ignored.
  - start=1 and stop=0 -> COUNT with acc=0, win_cnt=0, sat=0.
  - The hit on the start cycle is NOT counted. Window cycle 0 is the next clock.
  - start and stop together -> stay IDLE.
- COUNT:
  - busy=1. Each cycle samples hit into acc_next = acc + hit.
  - acc_next saturates at 2^CNT_W-1; an increment attempted while already saturated sets sat.
  - win_cnt increments each cycle.
  - start is ignored.
  - stop=1 -> IDLE, acc/win_cnt/sat cleared, no report, held outputs unchanged. This is checked before end-of-window.
- End of window (COUNT and win_cnt==WIN_LEN-1, stop=0):
  - The hit on this cycle is included.
  - Next cycle: cnt_out=acc_next, alarm=(acc_next>=THRESH), ovf=sat_next, cnt_valid=1 for exactly one cycle.
  - cont=1 -> stay COUNT with acc=0, win_cnt=0, sat=0. No clock lost between windows; the next window's cycle 0 is the next clock.
  - cont=0 -> IDLE; busy drops the same cycle cnt_valid rises.
- Latency: report is 1 clock after the window's last sampled cycle. Reports are spaced exactly WIN_LEN clocks apart in continuous mode.
- win_cnt width is clog2(WIN_LEN); it never exceeds WIN_LEN-1.
- Outside a report cycle, cnt_valid=0; cnt_out/alarm/ovf hold their values.

Decomposition:
- Shared package/header for the detector family: FSM state codes (IDLE, COUNT) and the default WIN_LEN/CNT_W/THRESH constants.
- One natural sub-module: seq_sat_cnt, a saturating up-counter with clear, inc and sticky sat flag, width CNT_W. It is used for acc.
- win_cnt stays inline.

Test Plan (WIN_LEN=8, CNT_W=5, THRESH=2 unless stated):
1. rst=1 for 3 clks with hit=1, start=1 -> busy, cnt_out, cnt_valid, alarm, ovf all 0 throughout and one cycle after release.
2. start pulse, cont=0, hits on window cycles 2 and 5 -> single cnt_valid pulse 1 clk after cycle 7; cnt_out=2, alarm=1, ovf=0; busy 0 from that cycle.
3. cont=1, window A hit at cycle 3, window B hits at cycles 0 and 7 -> cnt_valid pulses exactly 8 clks apart with cnt_out=1/alarm=0, then cnt_out=2/alarm=1. The cycle-7 hit belongs to B, not a third window.
4. CNT_W=2, hit=1 for all 8 cycles -> cnt_out=3, ovf=1, alarm=1. The next window with 0 hits reports cnt_out=0, ovf=0, alarm=0.
5. Prior report cnt_out=2; start, stop at cycle 4 -> no cnt_valid, busy 0 next clk, cnt_out stays 2. In IDLE, start+stop together -> busy stays 0.
6. rst asserted at window cycle 5 with hits pending -> all outputs 0 next clk, no cnt_valid. Hit on the start cycle itself is not counted (single hit there -> report cnt_out=0).

Source files
------------

// File: rtl/seq_hit_window_pkg.sv
// Shared definitions for the seq_1 pattern-detector family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_hit_window_pkg;

    // Window FSM state codes, 1-bit encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Default window geometry used by the detector family.
    localparam int DEF_WIN_LEN = 16;
    localparam int DEF_CNT_W   = 5;
    localparam int DEF_THRESH  = 3;

endpackage

// File: rtl/seq_hit_window_sat_cnt.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
// Latency: count registers 1 clk after i_inc; o_cnt_next/o_sat_next are same-cycle lookahead.
// Backpressure: none; i_inc is sampled every clock.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          clear count and sat on the next edge (wins over i_inc)
//   i_inc          increment request for this cycle
//   o_cnt, o_sat   registered count and sticky saturation flag
//   o_cnt_next     value the count would take this cycle if not cleared
//   o_sat_next     value sat would take this cycle if not cleared
module seq_sat_cnt
    import seq_hit_window_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_sat,
    output logic [W-1:0] o_cnt_next,
    output logic         o_sat_next
);

    logic [W-1:0] r_cnt;
    logic         r_sat;
    logic         w_at_max;

    assign w_at_max = &r_cnt;

    // The count holds at all-ones; only an increment attempted while already
    // there marks the sat flag, so reaching the maximum exactly is not overflow.
    assign o_cnt_next = (i_inc && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
    assign o_sat_next = r_sat | (i_inc & w_at_max);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= o_cnt_next;
            r_sat <= o_sat_next;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/seq_hit_window.sv
// Counts detector hits over a WIN_LEN-clock window; reports count, alarm and overflow per window.
// Latency: report (o_cnt_valid) 1 clk after the window's last sampled cycle.
// Backpressure: none; o_cnt_valid is a one-cycle pulse, report outputs hold until the next one.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_hit          one-cycle match pulse from the pattern detector
//   i_start        begin a window (honoured only in IDLE)
//   i_stop         abort the current window, wins over i_start
//   i_cont         sampled at window end: 1 = start next window immediately
//   o_busy         high while counting
//   o_cnt_out      hit count of the last completed window (held)
//   o_cnt_valid    one-cycle pulse when o_cnt_out/o_alarm/o_ovf update
//   o_alarm        last completed count >= THRESH (held)
//   o_ovf          accumulator saturated during last completed window (held)
module seq_hit_window
    import seq_hit_window_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hit,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_cont,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cnt_out,
    output logic             o_cnt_valid,
    output logic             o_alarm,
    output logic             o_ovf
);

    localparam int WC_W = $clog2(WIN_LEN);

    state_t             r_state;
    state_t             w_state_next;
    logic [WC_W-1:0]    r_win_cnt;
    logic [WC_W-1:0]    w_win_cnt_next;
    logic               w_win_last;
    logic               w_clr;
    logic               w_inc;
    logic               w_report;

    logic [CNT_W-1:0]   w_acc;
    logic               w_sat;
    logic [CNT_W-1:0]   w_acc_next;
    logic               w_sat_next;

    logic [CNT_W-1:0]   r_cnt_out;
    logic               r_cnt_valid;
    logic               r_alarm;
    logic               r_ovf;

    // Hits are only accumulated while counting; the start cycle is in IDLE,
    // so its hit never reaches the accumulator.
    assign w_inc      = (r_state == ST_COUNT) && i_hit;
    assign w_win_last = (r_win_cnt == WC_W'(WIN_LEN - 1));

    seq_sat_cnt #(
        .W (CNT_W)
    ) u_acc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_inc      (w_inc),
        .o_cnt      (w_acc),
        .o_sat      (w_sat),
        .o_cnt_next (w_acc_next),
        .o_sat_next (w_sat_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_win_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_win_cnt <= w_win_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_win_cnt_next = r_win_cnt;
        w_clr          = 1'b0;
        w_report       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_next   = ST_COUNT;
                    w_win_cnt_next = '0;
                    w_clr          = 1'b1;
                end
            end
            ST_COUNT: begin
                // Abort is checked ahead of end-of-window so a stop on the
                // last cycle suppresses the report.
                if (i_stop) begin
                    w_state_next   = ST_IDLE;
                    w_win_cnt_next = '0;
                    w_clr          = 1'b1;
                end else if (w_win_last) begin
                    // Report uses the lookahead values, so this cycle's hit
                    // is included while the accumulator clears for the next
                    // window with no lost clock.
                    w_report       = 1'b1;
                    w_clr          = 1'b1;
                    w_win_cnt_next = '0;
                    w_state_next   = i_cont ? ST_COUNT : ST_IDLE;
                end else begin
                    w_win_cnt_next = r_win_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_win_cnt_next = '0;
                w_clr          = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
            r_alarm     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_cnt_valid <= w_report;
            if (w_report) begin
                r_cnt_out <= w_acc_next;
                r_alarm   <= (w_acc_next >= CNT_W'(THRESH));
                r_ovf     <= w_sat_next;
            end
        end
    end

    assign o_busy      = (r_state == ST_COUNT);
    assign o_cnt_out   = r_cnt_out;
    assign o_cnt_valid = r_cnt_valid;
    assign o_alarm     = r_alarm;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_seq_hit_window.sv
// Directed bench for seq_hit_window: table of per-cycle vectors plus a saturation sequence.
// Latency: each vector's expectations are checked 1 time unit after the edge that samples it.
// Backpressure: n/a.
module tb_seq_hit_window;

    logic       clk = 1'b0;
    logic       rst, hit, start, stop, cont;

    logic       busy_a, valid_a, alarm_a, ovf_a;
    logic [4:0] cnt_a;
    logic       busy_b, valid_b, alarm_b, ovf_b;
    logic [1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_hit_window #(.WIN_LEN(8), .CNT_W(5), .THRESH(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_hit(hit), .i_start(start), .i_stop(stop),
        .i_cont(cont), .o_busy(busy_a), .o_cnt_out(cnt_a), .o_cnt_valid(valid_a),
        .o_alarm(alarm_a), .o_ovf(ovf_a)
    );

    seq_hit_window #(.WIN_LEN(8), .CNT_W(2), .THRESH(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_hit(hit), .i_start(start), .i_stop(stop),
        .i_cont(cont), .o_busy(busy_b), .o_cnt_out(cnt_b), .o_cnt_valid(valid_b),
        .o_alarm(alarm_b), .o_ovf(ovf_b)
    );

    typedef struct {
        logic rst, hit, start, stop, cont;
        logic busy, valid, alarm, ovf;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, h, s, p, c, b, v, a, o, input int n);
        vec_t e;
        e.rst = r; e.hit = h; e.start = s; e.stop = p; e.cont = c;
        e.busy = b; e.valid = v; e.alarm = a; e.ovf = o; e.cnt = n;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, h, s, p, c);
        rst = r; hit = h; start = s; stop = p; cont = c;
    endtask

    // Waits for dut_a's report, bounded; returns edges counted (-1 on timeout).
    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (valid_a) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        drive(1, 1, 1, 0, 0);

        // Reset held with hit/start active, then one idle cycle.
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single-shot window, hits on cycles 2 and 5.
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, (k == 2 || k == 5), 0, 0, 0, (k != 7), (k == 7), (k == 7), 0, (k == 7) ? 2 : 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);

        // Continuous windows: A hit at 3, B hits at 0 and 7; B ends with cont=0.
        add(0, 0, 1, 0, 1, 1, 0, 1, 0, 2);
        for (int k = 0; k < 8; k++)
            add(0, (k == 3), 0, 0, 1, 1, (k == 7), (k != 7), 0, (k == 7) ? 1 : 2);
        for (int k = 0; k < 8; k++)
            add(0, (k == 0 || k == 7), 0, 0, (k != 7), (k != 7), (k == 7), (k == 7), 0, (k == 7) ? 2 : 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 2);

        // Abort at cycle 4 keeps the previous report; start+stop in IDLE stays idle.
        add(0, 0, 1, 0, 0, 1, 0, 1, 0, 2);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 0, 0, 1, 0, 1, 0, 2);
        add(0, 1, 0, 1, 0, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
        add(0, 0, 1, 1, 0, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);

        // Reset at window cycle 5 with hits pending, then a window whose only
        // hit is on the start cycle.
        add(0, 0, 1, 0, 0, 1, 0, 1, 0, 2);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 0, 1, 0, 1, 0, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, (k != 7), (k == 7), 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].hit, tbl[i].start, tbl[i].stop, tbl[i].cont);
            @(posedge clk); #1;
            check("busy",      i, busy_a,  tbl[i].busy);
            check("cnt_valid", i, valid_a, tbl[i].valid);
            check("cnt_out",   i, cnt_a,   tbl[i].cnt);
            check("alarm",     i, alarm_a, tbl[i].alarm);
            check("ovf",       i, ovf_a,   tbl[i].ovf);
        end

        // Saturation: hit every cycle saturates the 2-bit accumulator, then an
        // empty continuous window must clear count, alarm and overflow.
        drive(0, 1, 1, 0, 1);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 1);
        wait_valid(n);
        check("sat_spacing", 0, n, 8);
        check("sat_cnt_b",   0, cnt_b, 3);
        check("sat_ovf_b",   0, ovf_b, 1);
        check("sat_alarm_b", 0, alarm_b, 1);
        check("sat_valid_b", 0, valid_b, 1);
        check("sat_cnt_a",   0, cnt_a, 8);
        check("sat_ovf_a",   0, ovf_a, 0);
        check("sat_busy_b",  0, busy_b, 1);
        drive(0, 0, 0, 0, 0);
        wait_valid(n);
        check("empty_spacing", 1, n, 8);
        check("empty_cnt_b",   1, cnt_b, 0);
        check("empty_ovf_b",   1, ovf_b, 0);
        check("empty_alarm_b", 1, alarm_b, 0);
        check("empty_busy_b",  1, busy_b, 0);
        @(posedge clk); #1;
        check("empty_pulse_b", 2, valid_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
